// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: watches a multiplexed, active-low 7-segment bus,
// waits for each selected digit to settle for STABLE_CYCLES samples and
// captures its decoded BCD value, tracking illegal patterns and bad scans.
module seg7_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg_an,
    input  logic [6:0]  seg_h,
    input  logic        clr,
    output logic [31:0] digits,
    output logic [7:0]  dig_valid,
    output logic [7:0]  err_digit,
    output logic        an_err,
    output logic        upd_valid,
    output logic [2:0]  upd_idx,
    output logic [3:0]  upd_bcd,
    output logic        frame_done
);

    localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);
    localparam logic [6:0] BLANK_H  = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HELD
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [7:0]  s_an, p_an;
    logic [6:0]  s_h, p_h;
    logic [7:0]  seen;

    logic [3:0]  an_low;
    logic        s_onehot;
    logic        s_multi;
    logic        changed;
    logic        capture;
    logic [2:0]  cap_idx;
    logic [3:0]  cap_bcd;
    logic        cap_blank;
    logic [7:0]  seen_set;
    logic        frame_full;

    // Number of active-low enables in a sample.
    function automatic logic [3:0] count_low(input logic [7:0] an);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!an[i]) n = n + 4'd1;
        end
        return n;
    endfunction

    // Index of the (single) low enable bit.
    function automatic logic [2:0] low_index(input logic [7:0] an);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!an[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Segment pattern to BCD; 4'hF for blank or illegal patterns.
    function automatic logic [3:0] decode(input logic [6:0] h);
        logic [3:0] v;
        case (h)
            7'b0000001: v = 4'd0;
            7'b1001111: v = 4'd1;
            7'b0010010: v = 4'd2;
            7'b0000110: v = 4'd3;
            7'b1001100: v = 4'd4;
            7'b0100100: v = 4'd5;
            7'b0100000: v = 4'd6;
            7'b0001111: v = 4'd7;
            7'b0000000: v = 4'd8;
            7'b0000100: v = 4'd9;
            default:    v = 4'hF;
        endcase
        return v;
    endfunction

    // Stability FSM next-state and capture decision.
    // The capture uses the previous sample (the last one inside the stable
    // window); if the newest sample already differs, tracking restarts on it
    // instead of parking in HELD so the new pattern is not lost.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        an_low     = count_low(s_an);
        s_onehot   = (an_low == 4'd1);
        s_multi    = (an_low >= 4'd2);
        changed    = (s_an != p_an) || (s_h != p_h);
        cap_idx    = low_index(p_an);
        cap_bcd    = decode(p_h);
        cap_blank  = (p_h == BLANK_H);
        seen_set   = seen | (8'd1 << cap_idx);
        frame_full = &seen_set;

        case (state)
            IDLE: begin
                if (s_onehot) begin
                    state_next = TRACK;
                    cnt_next   = 4'd1;
                end else begin
                    cnt_next   = '0;
                end
            end
            TRACK: begin
                if (cnt >= STABLE_N) begin
                    capture = 1'b1;
                    if (!changed) begin
                        state_next = HELD;
                        cnt_next   = STABLE_N;
                    end else if (s_onehot) begin
                        state_next = TRACK;
                        cnt_next   = 4'd1;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end else if (changed) begin
                    state_next = s_onehot ? TRACK : IDLE;
                    cnt_next   = s_onehot ? 4'd1 : 4'd0;
                end else begin
                    cnt_next   = cnt + 4'd1;
                end
            end
            HELD: begin
                if (changed) begin
                    state_next = s_onehot ? TRACK : IDLE;
                    cnt_next   = s_onehot ? 4'd1 : 4'd0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Input sampling: current and previous registered samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_an <= 8'hFF;
            s_h  <= 7'h7F;
            p_an <= 8'hFF;
            p_h  <= 7'h7F;
        end else begin
            s_an <= seg_an;
            s_h  <= seg_h;
            p_an <= s_an;
            p_h  <= s_h;
        end
    end

    // FSM state and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Captured digit state, error flags, frame tracking and update pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits     <= '1;
            dig_valid  <= '0;
            err_digit  <= '0;
            an_err     <= 1'b0;
            upd_valid  <= 1'b0;
            upd_idx    <= '0;
            upd_bcd    <= 4'hF;
            frame_done <= 1'b0;
            seen       <= '0;
        end else if (clr) begin
            digits     <= '1;
            dig_valid  <= '0;
            err_digit  <= '0;
            an_err     <= 1'b0;
            upd_valid  <= 1'b0;
            frame_done <= 1'b0;
            seen       <= '0;
        end else begin
            an_err     <= an_err | s_multi;
            upd_valid  <= capture;
            frame_done <= 1'b0;
            if (capture) begin
                upd_idx                      <= cap_idx;
                upd_bcd                      <= cap_bcd;
                digits[{cap_idx, 2'b00} +: 4] <= cap_bcd;
                dig_valid[cap_idx]           <= (cap_bcd != 4'hF);
                if (cap_bcd == 4'hF && !cap_blank) begin
                    err_digit[cap_idx] <= 1'b1;
                end
                if (frame_full) begin
                    frame_done <= 1'b1;
                    seen       <= '0;
                end else begin
                    seen       <= seen_set;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: randomized and directed stimulus; a run-length
// reference model schedules expected captures into a scoreboard queue that a
// negedge monitor drains whenever the DUT pulses upd_valid.
module tb_seg7_scan_decoder;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg_an;
    logic [6:0]  seg_h;
    logic        clr;
    logic [31:0] digits;
    logic [7:0]  dig_valid;
    logic [7:0]  err_digit;
    logic        an_err;
    logic        upd_valid;
    logic [2:0]  upd_idx;
    logic [3:0]  upd_bcd;
    logic        frame_done;

    seg7_scan_decoder #(.STABLE_CYCLES(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_an     (seg_an),
        .seg_h      (seg_h),
        .clr        (clr),
        .digits     (digits),
        .dig_valid  (dig_valid),
        .err_digit  (err_digit),
        .an_err     (an_err),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_bcd    (upd_bcd),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  idx;
        logic [3:0]  bcd;
        logic        fd;
        logic [31:0] digits;
        logic [7:0]  dv;
        logic [7:0]  err;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100};

    // reference model state
    logic [31:0] m_digits;
    logic [7:0]  m_dv, m_err, m_seen;
    logic        m_an;
    int          run_len;
    logic [7:0]  prev_an;
    logic [6:0]  prev_h;
    logic        prev_multi;
    logic        st1_v, st2_v;
    logic [7:0]  st1_an, st2_an;
    logic [6:0]  st1_h, st2_h;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_decode(input logic [6:0] h);
        for (int i = 0; i < 10; i++) if (h == pat[i]) return 4'(i);
        return 4'hF;
    endfunction

    function automatic int lows(input logic [7:0] an);
        return $countones(~an);
    endfunction

    task automatic model_reset();
        m_digits = '1; m_dv = '0; m_err = '0; m_seen = '0; m_an = 1'b0;
        run_len = 0; prev_an = 8'hFF; prev_h = 7'h7F; prev_multi = 1'b0;
        st1_v = 1'b0; st2_v = 1'b0;
    endtask

    task automatic model_apply(input logic [7:0] an, input logic [6:0] h);
        exp_t e;
        int   idx;
        logic [3:0] v;
        idx = 0;
        for (int i = 0; i < 8; i++) if (!an[i]) idx = i;
        v = ref_decode(h);
        m_digits[idx*4 +: 4] = v;
        m_dv[idx] = (v != 4'hF);
        if (v == 4'hF && h != 7'h7F) m_err[idx] = 1'b1;
        m_seen[idx] = 1'b1;
        e.fd = (m_seen == 8'hFF);
        if (e.fd) m_seen = '0;
        e.idx = 3'(idx); e.bcd = v; e.digits = m_digits; e.dv = m_dv; e.err = m_err;
        q.push_back(e);
    endtask

    // One clock edge of the model: sample (an,h,c) was taken at this edge.
    task automatic model_edge(input logic [7:0] an, input logic [6:0] h, input logic c);
        if (c) begin
            m_an = 1'b0;
            m_digits = '1; m_dv = '0; m_err = '0; m_seen = '0;
            st1_v = 1'b0; st2_v = 1'b0;
            run_len = 1;
        end else begin
            if (prev_multi) m_an = 1'b1;
            if (st2_v) model_apply(st2_an, st2_h);
            st2_v = st1_v; st2_an = st1_an; st2_h = st1_h;
            if (an == prev_an && h == prev_h) begin
                if (run_len < 1000) run_len++;
            end else begin
                run_len = 1;
            end
            st1_v = (run_len == N) && (lows(an) == 1);
            st1_an = an; st1_h = h;
        end
        prev_an = an; prev_h = h; prev_multi = (lows(an) >= 2);
    endtask

    task automatic step(input logic [7:0] an, input logic [6:0] h, input logic c);
        seg_an = an; seg_h = h; clr = c;
        @(posedge clk);
        model_edge(an, h, c);
        #1;
    endtask

    task automatic hold(input logic [7:0] an, input logic [6:0] h, input int n);
        for (int i = 0; i < n; i++) step(an, h, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " digits"},     digits,     32'hFFFFFFFF);
        check({tag, " dig_valid"},  dig_valid,  8'h00);
        check({tag, " err_digit"},  err_digit,  8'h00);
        check({tag, " an_err"},     an_err,     1'b0);
        check({tag, " upd_valid"},  upd_valid,  1'b0);
        check({tag, " upd_idx"},    upd_idx,    3'd0);
        check({tag, " upd_bcd"},    upd_bcd,    4'hF);
        check({tag, " frame_done"}, frame_done, 1'b0);
    endtask

    task automatic check_state(input string tag);
        check({tag, " digits"},    digits,    m_digits);
        check({tag, " dig_valid"}, dig_valid, m_dv);
        check({tag, " err_digit"}, err_digit, m_err);
        check({tag, " an_err"},    an_err,    m_an);
    endtask

    // Scoreboard monitor: pops one expected capture per upd_valid pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (upd_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected upd_valid: idx=%0d bcd=%h expected no capture at %0t",
                             upd_idx, upd_bcd, $time);
                end else begin
                    e = q.pop_front();
                    check("upd_idx",      upd_idx,    e.idx);
                    check("upd_bcd",      upd_bcd,    e.bcd);
                    check("frame_done",   frame_done, e.fd);
                    check("cap digits",   digits,     e.digits);
                    check("cap dig_valid", dig_valid, e.dv);
                    check("cap err_digit", err_digit, e.err);
                end
            end else begin
                check("idle frame_done", frame_done, 1'b0);
            end
        end
    end

    initial begin
        logic [7:0] ran;
        logic [6:0] rh;
        int len;
        logic rc;

        rst_n = 1'b0; seg_an = 8'hFF; seg_h = 7'h7F; clr = 1'b0;
        model_reset();
        #12;
        check_reset_values("reset");
        rst_n = 1'b1;

        // single digit 0 showing 2, held well beyond the window
        hold(8'hFE, 7'b0010010, 10);
        check_state("digit0=2");
        check("digit0 nibble", digits[3:0], 4'd2);

        // digit 1 showing 5 with a one-cycle glitch
        hold(8'hFD, 7'b0100100, 2);
        step(8'hFD, 7'b0100000, 1'b0);
        hold(8'hFD, 7'b0100100, 7);
        check_state("glitch");

        // clear, then scan digits 0..7 with values 1..8
        step(8'hFF, 7'h7F, 1'b1);
        for (int d = 0; d < 8; d++) begin
            logic [7:0] an;
            an = 8'hFF;
            an[d] = 1'b0;
            hold(an, pat[d + 1], 6);
        end
        hold(8'hFF, 7'h7F, 3);
        check_state("scan");
        check("scan digits", digits, 32'h87654321);
        check("scan dig_valid", dig_valid, 8'hFF);

        // illegal pattern on digit 3, then two enables low
        hold(8'hF7, 7'b1110000, 7);
        check("illegal err_digit3", err_digit[3], 1'b1);
        check("illegal dig_valid3", dig_valid[3], 1'b0);
        hold(8'hFC, 7'b0000001, 8);
        check_state("an_err");
        check("an_err set", an_err, 1'b1);

        // clr landing exactly in the capture-update cycle
        hold(8'hFB, 7'b0001111, 5);
        step(8'hFB, 7'b0001111, 1'b1);
        check("clr digits", digits, 32'hFFFFFFFF);
        check("clr dig_valid", dig_valid, 8'h00);
        check("clr err_digit", err_digit, 8'h00);
        check("clr an_err", an_err, 1'b0);
        hold(8'hFB, 7'b0001111, 7);
        check_state("after clr");

        // reset pulsed mid-TRACK
        hold(8'hEF, 7'b0000110, 3);
        rst_n = 1'b0;
        model_reset();
        #2;
        check_reset_values("mid reset");
        rst_n = 1'b1;
        hold(8'hEF, 7'b0000110, 8);
        check_state("after reset");

        // randomized scanning
        for (int s = 0; s < 80; s++) begin
            case ($urandom_range(0, 9))
                7:       ran = 8'hFF;
                8, 9:    ran = 8'($urandom);
                default: begin ran = 8'hFF; ran[$urandom_range(0, 7)] = 1'b0; end
            endcase
            case ($urandom_range(0, 5))
                0:       rh = 7'($urandom);
                1:       rh = 7'h7F;
                default: rh = pat[$urandom_range(0, 9)];
            endcase
            len = $urandom_range(1, 8);
            rc = ($urandom_range(0, 25) == 0);
            step(ran, rh, rc);
            hold(ran, rh, len - 1);
        end
        hold(8'hFF, 7'h7F, 6);
        check_state("random end");
        check("scoreboard drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
